// File: rtl/pdp8_trace.sv
// pdp8_trace: PDP-8 fetch tracer with periodic/all-fetch sampling, halt/limit records and a record FIFO.
// Define PDP8_TRACE_STALL_EN to back-pressure the CPU through cpu_stall instead of counting drops.
module pdp8_trace #(
   parameter int SAMPLE_INTERVAL = 5000,
   parameter int FIFO_DEPTH = 16,
   parameter int CYCLE_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         state,
   input  logic [11:0]        pc,
   input  logic [11:0]        mb,
   input  logic [11:0]        ac,
   input  logic               l,
   input  logic               ion,
   input  logic [2:0]         IF,
   input  logic [2:0]         DF,
   input  logic               show_all,
   input  logic [CYCLE_W-1:0] max_cycles,
   output logic               trace_valid,
   output logic [47:0]        trace_data,
   input  logic               trace_ready,
   output logic               halted,
   output logic               limit_hit,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic [15:0]        dropped,
   output logic               cpu_stall
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {RUN, HALT, LIMIT} mode_t;
   mode_t r_mode;
   logic [CYCLE_W-1:0] r_cc, r_samp, w_cc_inc;
   logic [47:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wp, r_rp;
   logic [15:0] r_drop;
   logic w_fetch, w_sampled, w_halt, w_limit, w_push, w_pop, w_full, w_wr;
   logic [1:0] w_type;
   logic [47:0] w_rec;
   assign w_fetch = r_mode == RUN && state == 4'b0000;
   assign w_cc_inc = (&r_cc) ? r_cc : r_cc + 1'b1;
   assign w_sampled = w_fetch && (r_samp + 1'b1 == CYCLE_W'(SAMPLE_INTERVAL));
   assign w_halt = r_mode == RUN && state == 4'b1100;
   assign w_limit = w_fetch && max_cycles != '0 && w_cc_inc >= max_cycles;
   // Only one record fits per cycle: halt beats limit, and a limit fetch replaces its sample record.
   assign w_type = w_halt ? 2'b01 : w_limit ? 2'b10 : 2'b00;
   assign w_push = w_halt || w_limit || (w_fetch && (show_all || w_sampled));
   assign w_rec = {w_type, IF, DF, pc, mb, l, ac, ion, 2'b00};
   assign w_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign trace_valid = r_wp != r_rp;
   assign trace_data = r_mem[r_rp[AW-1:0]];
   assign w_pop = trace_valid && trace_ready;
   assign w_wr = w_push && (!w_full || w_pop);
   assign halted = r_mode == HALT;
   assign limit_hit = r_mode == LIMIT;
   assign cycle_count = r_cc;
   assign dropped = r_drop;
`ifdef PDP8_TRACE_STALL_EN
   logic [AW:0] w_cnt;
   assign w_cnt = r_wp - r_rp;
   assign cpu_stall = w_cnt >= (AW+1)'(FIFO_DEPTH - 1);
`else
   assign cpu_stall = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= RUN;
         r_cc <= '0;
         r_samp <= '0;
         r_drop <= '0;
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_halt) r_mode <= HALT;
         else if (w_limit) r_mode <= LIMIT;
         if (w_fetch) begin
            r_cc <= w_cc_inc;
            r_samp <= w_sampled ? '0 : r_samp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_wr) r_wp <= r_wp + 1'b1;
`ifndef PDP8_TRACE_STALL_EN
         if (w_push && !w_wr && !(&r_drop)) r_drop <= r_drop + 1'b1;
`endif
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr && !reset) r_mem[r_wp[AW-1:0]] <= w_rec;
   end
endmodule

// File: doc/pdp8_trace.md
PDP8_TRACE -- requirements
Module: pdp8_trace

Interface
REQ-001 SHALL have parameter SAMPLE_INTERVAL, default 5000: fetches between periodic samples, >=1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: record FIFO entries, power of two, >=2.
REQ-003 SHALL have parameter CYCLE_W, default 32: width of the fetch counter and limit.
REQ-004 SHALL have ports clk in 1 (single clock) and reset in 1 (synchronous, active-high); all logic in the clk domain.
REQ-005 SHALL have port state in 4: CPU major state; 4'b0000 = F0 (fetch), 4'b1100 = halt.
REQ-006 SHALL have ports pc in 12, mb in 12, ac in 12, l in 1, ion in 1, IF in 3, DF in 3: CPU registers.
REQ-007 SHALL have port show_all in 1: record every fetch when high.
REQ-008 SHALL have port max_cycles in CYCLE_W: fetch limit; 0 = unlimited.
REQ-009 SHALL have ports trace_valid out 1, trace_data out 48, trace_ready in 1: FIFO read side, valid/ready.
REQ-010 SHALL have ports halted out 1, limit_hit out 1, cycle_count out CYCLE_W, dropped out 16.
REQ-011 SHALL have port cpu_stall out 1: request to hold the CPU; meaningful only with PDP8_TRACE_STALL_EN.

Function
REQ-012 SHALL treat each clk edge with state==4'b0000 as one fetch event, with recording enabled only in RUN.
REQ-013 SHALL increment cycle_count by 1 per fetch event in RUN, saturating at all-ones.
REQ-014 SHALL keep a sample counter that increments per fetch event and, on reaching SAMPLE_INTERVAL, clears to 0 and marks that fetch as sampled.
REQ-015 SHALL build record {type[1:0], IF, DF, pc, mb, l, ac, ion, 2'b00} MSB-first; type 00 = sample, 01 = halt, 10 = limit.
REQ-016 SHALL push a type-00 record on a fetch event if show_all=1 or that fetch is sampled, using values present in that same cycle.
REQ-017 SHALL use three states: RUN, HALT, LIMIT. RUN->HALT when state==4'b1100; RUN->LIMIT when max_cycles!=0 and the incremented cycle_count >= max_cycles; HALT and LIMIT leave only on reset.
REQ-018 SHALL push exactly one type-01 record on the RUN->HALT transition and exactly one type-10 record on the RUN->LIMIT transition; if both conditions hold in one cycle, HALT wins.
REQ-019 SHALL assert halted in HALT and limit_hit in LIMIT, both level outputs.
REQ-020 SHALL drive trace_valid when the FIFO is non-empty; trace_data is the head entry, and a pop occurs when trace_valid&trace_ready on a clk edge.
REQ-021 SHALL allow a simultaneous push and pop when full; both occur and the count is unchanged.
REQ-022 SHALL, without the stall macro, discard a push to a full FIFO with no pop, incrementing dropped (saturating at 16'hFFFF); halt and limit records are treated the same way.
REQ-023 SHALL have FIFO latency of 1 clock: a record pushed at edge N is visible at trace_valid after edge N.
REQ-024 SHALL use wrap-around read/write pointers of log2(FIFO_DEPTH)+1 bits; full = MSBs differ and remaining bits equal.

Reset
REQ-025 SHALL, on reset high at a clk edge, set state to RUN, empty the FIFO, and zero cycle_count, the sample counter, dropped, halted, limit_hit, cpu_stall and trace_valid.
REQ-026 SHALL, on reset mid-transfer, discard the pending head record; no push occurs in a reset cycle.

Configuration
REQ-027 SHALL use macro PDP8_TRACE_STALL_EN: when defined, cpu_stall = FIFO count >= FIFO_DEPTH-1, so no record is dropped given a one-fetch stall response, and dropped stays 0; when undefined, cpu_stall is tied 0 and the drop rule of REQ-022 applies.

Verification
REQ-028 SHALL cover periodic sampling: SAMPLE_INTERVAL=4, show_all=0, 12 fetches, ready=1 -> 3 type-00 records at fetches 4, 8 and 12; cycle_count=12.
REQ-029 SHALL cover the halt record: state=4'b1100 with pc=12'o0207 -> one record with type 01 and pc field 0207, halted=1, and no further records until reset.
REQ-030 SHALL cover the cycle limit: max_cycles=100, show_all=0 -> limit_hit=1 after fetch 100, one type-10 record, and cycle_count=100 frozen.
REQ-031 SHALL cover overflow: FIFO_DEPTH=4, show_all=1, ready=0, 10 fetches -> 4 entries held; dropped=6 without the macro; with the macro, cpu_stall=1 from count 3 and dropped=0.
REQ-032 SHALL cover full with simultaneous push and pop: ready=1 while full, show_all=1 -> count stays 4 and records are delivered in order.
REQ-033 SHALL cover reset in HALT: pulse reset -> RUN, FIFO empty, all counters 0, and sampling resumes.
